// File: rtl/shreg_seq_pkg.sv
// Shared definitions for the shift register sequencer.
// Holds the register mode / command op codes, the shift direction
// constants and the sequencer FSM state encoding.
package shreg_seq_pkg;

    // Register mode codes, also used as command op codes.
    localparam logic [1:0] SHIFT      = 2'b00;
    localparam logic [1:0] CIRC_SHIFT = 2'b01;
    localparam logic [1:0] PARA_LOAD  = 2'b10;
    localparam logic [1:0] CLEAR      = 2'b11;

    // Shift direction.
    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FINISH  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/shreg_seq_counter.sv
// 3-bit loadable down counter timing the SHIFT state.
// A load value of 0 runs for 8 decrements (0,7,6,...,1); last is high
// while the count sits at 1, i.e. during the final SHIFT cycle.
// Ports: clk, rst_n (async low), load/load_val (preset), dec (count
// down one), last (final cycle flag).
module shreg_seq_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       last
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec)
            cnt_d = cnt_q - 3'd1;   // 0 wraps to 7, giving 8 cycles
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 3'd0;
        else        cnt_q <= cnt_d;
    end

    assign last = (cnt_q == 3'd1);

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer driving an external 4-bit shift register.
// Accepts one command (shift, circular shift, parallel load, clear),
// optionally preloads the register, shifts it N times while streaming
// the outgoing bit, captures the register into RESULT and pulses DONE.
// ABORT cancels an active command; register enable drops in the same
// cycle and ABORTED pulses once the FSM is back in IDLE.
// Ports: clk/rst_n; cmd_* handshake and fields; abort; reg_* drive and
// sense the register; ser_bit/ser_valid serial stream; result, done,
// err, aborted status.
// Build option: SHREG_SEQ_CLEAR_EN enables the clear op; otherwise a
// clear command finishes immediately with err=1.
import shreg_seq_pkg::*;

module shift_reg_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_dir,
    input  logic [2:0] cmd_count,
    input  logic       cmd_preload,
    input  logic [3:0] cmd_data,
    input  logic       cmd_sin,
    input  logic       abort,
    output logic       reg_enb,
    output logic       reg_dir,
    output logic       reg_s_in,
    output logic [1:0] reg_modo,
    output logic [3:0] reg_d,
    input  logic [3:0] reg_q,
    input  logic       reg_s_out,
    output logic       ser_bit,
    output logic       ser_valid,
    output logic [3:0] result,
    output logic       done,
    output logic       err,
    output logic       aborted
);

    seq_state_e state_q, state_d;
    logic [1:0] op_q, op_d;
    logic       dir_q, dir_d, sin_q, sin_d;
    logic [3:0] data_q, data_d, result_q, result_d;
    logic       err_q, err_d, aborted_q, aborted_d, ready_q;
    logic       cnt_load, cnt_last;
    logic [2:0] cnt_val;
    logic       accept, in_load, in_shift, busy;

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dir_d     = dir_q;
        sin_d     = sin_q;
        data_d    = data_q;
        result_d  = result_q;
        err_d     = err_q;
        aborted_d = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = cmd_count;
        case (state_q)
            ST_IDLE: if (accept) begin
                op_d     = cmd_op;
                dir_d    = cmd_dir;
                sin_d    = cmd_sin;
                data_d   = cmd_data;
                err_d    = 1'b0;
                cnt_load = 1'b1;
                case (cmd_op)
                    SHIFT, CIRC_SHIFT: state_d = cmd_preload ? ST_LOAD : ST_SHIFT;
                    PARA_LOAD:         state_d = ST_LOAD;
                    default: begin
`ifdef SHREG_SEQ_CLEAR_EN
                        // Clear is a single SHIFT-state cycle in mode 11.
                        state_d = ST_SHIFT;
                        cnt_val = 3'd1;
`else
                        state_d = ST_FINISH;
                        err_d   = 1'b1;
`endif
                    end
                endcase
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = (op_q == PARA_LOAD) ? ST_CAPTURE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_last) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    result_d = reg_q;
                    state_d  = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= 2'b00;
            dir_q     <= 1'b0;
            sin_q     <= 1'b0;
            data_q    <= 4'b0000;
            result_q  <= 4'b0000;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dir_q     <= dir_d;
            sin_q     <= sin_d;
            data_q    <= data_d;
            result_q  <= result_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
            ready_q   <= 1'b1;   // holds ready low until the first clock after reset
        end
    end

    shreg_seq_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (in_shift),
        .last     (cnt_last)
    );

    // Output decode from the state flop; abort gates the enable
    // combinationally so the register never moves in an aborted cycle.
    assign in_load   = (state_q == ST_LOAD);
    assign in_shift  = (state_q == ST_SHIFT);
    assign busy      = (state_q != ST_IDLE);
    assign reg_enb   = (in_load || in_shift) && !abort;
    assign reg_modo  = in_load ? PARA_LOAD : (in_shift ? op_q : SHIFT);
    assign reg_d     = in_load ? data_q : 4'b0000;
    assign reg_dir   = busy && dir_q;
    assign reg_s_in  = busy && sin_q;
    assign ser_valid = in_shift && !abort;
    assign ser_bit   = ser_valid && reg_s_out;
    assign cmd_ready = ready_q && (state_q == ST_IDLE);
    assign done      = (state_q == ST_FINISH);
    assign err       = (state_q == ST_FINISH) && err_q;
    assign aborted   = aborted_q;
    assign result    = result_q;

endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, listed first in the port order below.
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RST_N  input  1  asynchronous reset, active low.
REQ-004 CMD_VALID  input  1  requester presents a command.
REQ-005 CMD_READY  output  1  sequencer accepts a command; a command is accepted on a cycle with CMD_VALID=1 and CMD_READY=1.
REQ-006 CMD_OP  input  2  00 shift, 01 circular shift, 10 parallel load, 11 clear.
REQ-007 CMD_DIR  input  1  0 left, 1 right; passed to REG_DIR.
REQ-008 CMD_COUNT  input  3  number of shifts, 1-7; 0 means 8.
REQ-009 CMD_PRELOAD  input  1  for shift ops only: load CMD_DATA before shifting.
REQ-010 CMD_DATA  input  4  parallel load word.
REQ-011 CMD_SIN  input  1  serial fill bit, held on REG_S_IN for the whole command.
REQ-012 ABORT  input  1  cancel the command in progress.
REQ-013 REG_ENB, REG_DIR, REG_S_IN  output  1 each  drive the 4-bit register; REG_ENB=1 enables it.
REQ-014 REG_MODO  output  2  register mode, same encoding as CMD_OP.
REQ-015 REG_D  output  4  register parallel input.
REQ-016 REG_Q  input  4; REG_S_OUT  input  1: register outputs.
REQ-017 SER_BIT / SER_VALID  output  1/1  bit leaving the register, qualified per shift cycle.
REQ-018 RESULT  output  4; DONE, ERR, ABORTED  output  1 each.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, SHIFT, CAPTURE, FINISH; CMD_READY=1 only in IDLE.
REQ-020 On accept, the block SHALL latch OP, DIR, COUNT, PRELOAD, DATA and SIN; later input changes have no effect.
REQ-021 IDLE->LOAD when OP=10, or OP in {00,01} with PRELOAD=1; IDLE->SHIFT when OP in {00,01} with PRELOAD=0; LOAD->SHIFT for shift ops; LOAD->CAPTURE for OP=10.
REQ-022 LOAD: REG_ENB=1, REG_MODO=10, REG_D=latched DATA, for exactly one cycle.
REQ-023 SHIFT: REG_ENB=1, REG_MODO=latched OP, for exactly N cycles (N=COUNT, or 8 if COUNT=0); then ->CAPTURE.
REQ-024 Each SHIFT cycle: SER_VALID=1, SER_BIT=REG_S_OUT, i.e. the pre-edge bit (Q[3] left, Q[0] right).
REQ-025 CAPTURE: REG_ENB=0; RESULT loads REG_Q; ->FINISH.
REQ-026 FINISH: DONE=1 for one cycle with ERR valid; ->IDLE.
REQ-027 In all other states, REG_ENB=0 and SER_VALID=0.
REQ-028 Latency from accept cycle T: load T+3 DONE; shift T+N+2; shift with preload T+N+3.
REQ-029 ABORT=1 in LOAD/SHIFT/CAPTURE SHALL force REG_ENB=0 that same cycle, pulse ABORTED next cycle with the FSM in IDLE, hold RESULT and leave DONE=0.
REQ-030 ABORT in IDLE/FINISH SHALL be ignored; FINISH completes normally.

Reset
REQ-031 While RST_N=0: FSM=IDLE, CMD_READY=0, all other outputs 0 (RESULT=0000, REG_MODO=00); CMD_READY=1 from the first clock after release.
REQ-032 Reset mid-command SHALL drop REG_ENB immediately (asynchronously); no DONE or ABORTED is produced.

Configuration
REQ-033 With SHREG_SEQ_CLEAR_EN defined, OP=11 SHALL take one SHIFT-type cycle with REG_ENB=1 and REG_MODO=11 (register zeroed), then CAPTURE/FINISH with ERR=0.
REQ-034 Without SHREG_SEQ_CLEAR_EN, OP=11 SHALL go IDLE->FINISH with DONE=1 and ERR=1; REG_ENB is never asserted and RESULT is unchanged.

Structure
REQ-035 Package shreg_seq_pkg SHALL hold the mode/op codes (SHIFT, CIRC_SHIFT, PARA_LOAD, CLEAR), the LEFT/RIGHT constants and the state enum.
REQ-036 One sub-module, shreg_seq_counter (3-bit loadable down counter, 0 means 8, with a last flag), SHALL time the SHIFT state.

Verification
REQ-037 Load, DATA=1010 -> one cycle REG_MODO=10; RESULT=1010 and DONE at T+3.
REQ-038 Shift left, PRELOAD, DATA=1001, COUNT=2, SIN=0 -> SER_BIT 1,0; RESULT=0100; DONE at T+5.
REQ-039 Circular right, PRELOAD, DATA=0001, COUNT=0 -> 8 SER_VALID cycles; RESULT=0001.
REQ-040 ABORT in the 2nd SHIFT cycle of COUNT=5 -> REG_ENB=0 that cycle; ABORTED next cycle; DONE never asserted; CMD_READY=1.
REQ-041 OP=11 -> with the macro: RESULT=0000, ERR=0; without it: DONE with ERR=1 and REG_ENB never high.
REQ-042 RST_N pulsed low mid-SHIFT -> all outputs 0 at once; CMD_READY=1 one clock after release.
